fp_converter_i32_to_f32: RTL and testbench
==========================================

Name: fp_converter_i32_to_f32

Overview:
Multi-cycle integer-to-single-precision converter for RISC-V FCVT.S.W and FCVT.S.WU. It is the reverse-direction companion of the f32-to-i32 converter path in FpConverter. It takes a 32-bit integer through an in/out valid handshake, normalizes iteratively (up to NORM_STEP bits per cycle) and rounds per the RISC-V rounding mode. It produces an fp32 result plus fflags for the FP writeback stage.

Parameters:
NORM_STEP, 4, coarse left-shift per normalize cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
kill  input  1  synchronous abort of the in-flight conversion (pipeline flush)
inValid  input  1  request valid
inReady  output  1  block can accept; equals (state==IDLE && !rst)
command  input  FpConverterCommand  FpConverterCommand_S_W (signed) or FpConverterCommand_S_WU (unsigned)
roundingMode  input  3  FRM_RNE/RTZ/RDN/RUP/RMM, already resolved (no DYN)
intSrc  input  32  integer operand
outValid  output  1  one-cycle pulse, result valid
fpResult  output  32  fp32 result, registered
flags  output  fflags_t  NV/DZ/OF/UF always 0; NX = inexact

Behaviour:
- Reset (async): state=IDLE, outValid=0, fpResult=0, flags=0, internal registers=0.
- Accept: inValid && inReady && !kill at a rising edge.
- On accept, capture:
  - sign = (S_W && intSrc[31]).
  - mag = sign ? -intSrc : intSrc, as unsigned 32 bits; 0x80000000 is kept as magnitude 2^31.
  - exp = 158 (8-bit), rm = roundingMode.
  - Next state is NORM, or ROUND if mag==0.
- NORM: exactly one action per cycle, in priority order:
  - mag[31]==1 -> go to ROUND, no shift.
  - mag[31 -: NORM_STEP]==0 -> mag <<= NORM_STEP, exp -= NORM_STEP.
  - otherwise -> mag <<= 1, exp -= 1.
- ROUND:
  - Fields: mant = mag[31:8], g = mag[7], r = mag[6], s = |mag[5:0]; inexact = g|r|s.
  - Increment by mode:
    - RNE: g && (r|s|mant[0]).
    - RTZ: 0.
    - RDN: sign && inexact.
    - RUP: !sign && inexact.
    - RMM: g.
    - Any other rm value: treat as RNE.
  - Mantissa carry: if mant+inc overflows 24 bits, mant = 0x800000 and exp += 1. Exponent overflow is impossible (max 159).
  - Register fpResult = {sign, exp, mant[22:0]}, flags.NX = inexact, outValid = 1 next cycle. Go to IDLE.
  - mag==0 -> fpResult = 0x00000000 (+0 in every mode), flags = 0.
- outValid is high for exactly one cycle. fpResult/flags hold their values until the next ROUND.
- Latency: accept at edge E0; k NORM cycles, then 1 ROUND cycle; outValid high in cycle k+2 after E0. A zero input gives outValid in cycle 2.
- Back-to-back: inReady is high in the same cycle as outValid, so a new accept is legal there.
- kill: highest priority in every state.
  - Next state is IDLE and no outValid is produced.
  - A kill in ROUND suppresses the outValid that would follow.
  - kill together with inValid in IDLE performs no accept.
  - kill does not clear fpResult/flags.
- rst mid-operation: immediate IDLE; outValid is dropped.
- inValid while busy is ignored (inReady=0); the requester holds the request.

Decomposition:
- Package (OpTypes/RvTypes): add FpConverterCommand_S_W and FpConverterCommand_S_WU.
- Package: converter state enum (IDLE, NORM, ROUND).
- Package: constant FP32_BIAS_PLUS_31 = 158. FRM_* constants and fflags_t already exist.
- Sub-module fp_converter_round_i32_to_f32 (combinational): inputs sign, exp, mag, rm; outputs packed fp32 and inexact. It mirrors the existing f32-to-i32 rounding helper.

Test Plan:
- S_W 0x00000001 RNE, NORM_STEP=4 -> 7 coarse shifts + 3 single shifts + exit (k=11); outValid 13 cycles after accept; fpResult 0x3F800000, flags 0.
- S_W 0xFFFFFFFF -> 0xBF800000, NX=0. S_W 0x80000000 -> 0xCF000000. S_WU 0x80000000 -> 0x4F000000 with k=1, outValid at cycle 3.
- S_W 0x7FFFFFFF: RNE -> 0x4F000000 NX=1; RTZ -> 0x4EFFFFFF NX=1. S_WU 0xFFFFFFFF: RUP -> 0x4F800000; RDN -> 0x4F7FFFFF; both NX=1.
- S_W 0x01000001 tie case: RNE -> 0x4B800000 NX=1; RMM -> 0x4B800001 NX=1. S_W 0xFEFFFFFF (-(2^24+1)) RDN -> 0xCB800001; RUP -> 0xCB800000.
- Zero in S_W with RDN -> 0x00000000, flags 0, outValid at cycle 2. Back-to-back: new inValid accepted in the outValid cycle, and its result is correct.
- Assert kill during NORM of 0x00000001 -> no outValid, inReady next cycle, previous fpResult unchanged. Assert rst mid-NORM -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fp_converter_i32_to_f32_pkg.sv
// Shared types and constants for the int32 -> fp32 converter.
// Holds the command encodings, rounding modes, fflags layout and converter state.
package fp_converter_i32_to_f32_pkg;

    typedef enum logic [1:0] {
        FpConverterCommand_S_W  = 2'd0,
        FpConverterCommand_S_WU = 2'd1
    } FpConverterCommand;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } cvt_state_e;

    localparam logic [2:0] FRM_RNE = 3'd0;
    localparam logic [2:0] FRM_RTZ = 3'd1;
    localparam logic [2:0] FRM_RDN = 3'd2;
    localparam logic [2:0] FRM_RUP = 3'd3;
    localparam logic [2:0] FRM_RMM = 3'd4;

    // Exponent of a value whose leading one sits at bit 31 of the magnitude.
    localparam logic [7:0] FP32_BIAS_PLUS_31 = 8'd158;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

endpackage

// File: rtl/fp_converter_round_i32_to_f32.sv
// Combinational rounding of a normalized 32-bit magnitude into a packed fp32.
// A zero magnitude yields +0 with no inexact flag.
module fp_converter_round_i32_to_f32
    import fp_converter_i32_to_f32_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [31:0] mag,
    input  logic [2:0]  rm,
    output logic [31:0] fp,
    output logic        inexact
);

    logic [23:0] mant;
    logic        g;
    logic        r;
    logic        s;
    logic        inc;
    logic [24:0] sum;
    logic [23:0] mant_r;
    logic [7:0]  exp_r;

    always_comb begin
        mant    = mag[31:8];
        g       = mag[7];
        r       = mag[6];
        s       = |mag[5:0];
        inexact = g | r | s;

        case (rm)
            FRM_RTZ: inc = 1'b0;
            FRM_RDN: inc = sign & inexact;
            FRM_RUP: inc = ~sign & inexact;
            FRM_RMM: inc = g;
            default: inc = g & (r | s | mant[0]);
        endcase

        sum = {1'b0, mant} + {24'd0, inc};
        if (sum[24]) begin
            mant_r = 24'h800000;
            exp_r  = exp + 8'd1;
        end else begin
            mant_r = sum[23:0];
            exp_r  = exp;
        end

        // Only a zero operand reaches here without its hidden bit set; mask it to +0.
        fp = {sign, exp_r, mant_r[22:0]} & {32{mant_r[23]}};
    end

endmodule

// File: rtl/fp_converter_i32_to_f32.sv
// Multi-cycle FCVT.S.W / FCVT.S.WU: captures an int32, normalizes up to NORM_STEP
// bits per cycle, rounds per the resolved RISC-V mode and pulses outValid.
module fp_converter_i32_to_f32
    import fp_converter_i32_to_f32_pkg::*;
#(
    parameter int NORM_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              inValid,
    output logic              inReady,
    input  FpConverterCommand command,
    input  logic [2:0]        roundingMode,
    input  logic [31:0]       intSrc,
    output logic              outValid,
    output logic [31:0]       fpResult,
    output fflags_t           flags
);

    cvt_state_e  state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic [2:0]  rm_q, rm_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] fp_result_q, fp_result_d;
    fflags_t     flags_q, flags_d;

    logic [31:0] round_fp;
    logic        round_inexact;

    fp_converter_round_i32_to_f32 u_round (
        .sign    (sign_q),
        .exp     (exp_q),
        .mag     (mag_q),
        .rm      (rm_q),
        .fp      (round_fp),
        .inexact (round_inexact)
    );

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        rm_d        = rm_q;
        out_valid_d = 1'b0;
        fp_result_d = fp_result_q;
        flags_d     = flags_q;

        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inValid) begin
                        sign_d  = (command == FpConverterCommand_S_W) && intSrc[31];
                        mag_d   = sign_d ? (~intSrc + 32'd1) : intSrc;
                        exp_d   = FP32_BIAS_PLUS_31;
                        rm_d    = roundingMode;
                        state_d = (mag_d == '0) ? ROUND : NORM;
                    end
                end
                NORM: begin
                    if (mag_q[31]) begin
                        state_d = ROUND;
                    end else if (mag_q[31 -: NORM_STEP] == '0) begin
                        mag_d = mag_q << NORM_STEP;
                        exp_d = exp_q - 8'(NORM_STEP);
                    end else begin
                        mag_d = mag_q << 1;
                        exp_d = exp_q - 8'd1;
                    end
                end
                ROUND: begin
                    fp_result_d = round_fp;
                    flags_d     = '{nv: 1'b0, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: round_inexact};
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= '0;
            rm_q        <= '0;
            out_valid_q <= 1'b0;
            fp_result_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            rm_q        <= rm_d;
            out_valid_q <= out_valid_d;
            fp_result_q <= fp_result_d;
            flags_q     <= flags_d;
        end
    end

    assign inReady  = (state_q == IDLE) && !rst;
    assign outValid = out_valid_q;
    assign fpResult = fp_result_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_fp_converter_i32_to_f32.sv
// Directed bench for fp_converter_i32_to_f32 with hand-computed fp32 results.
module tb_fp_converter_i32_to_f32;
    import fp_converter_i32_to_f32_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              kill = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    FpConverterCommand command = FpConverterCommand_S_W;
    logic [2:0]        roundingMode = 3'd0;
    logic [31:0]       intSrc = '0;
    logic              outValid;
    logic [31:0]       fpResult;
    fflags_t           flags;

    int checks = 0;
    int errors = 0;

    fp_converter_i32_to_f32 #(.NORM_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .kill         (kill),
        .inValid      (inValid),
        .inReady      (inReady),
        .command      (command),
        .roundingMode (roundingMode),
        .intSrc       (intSrc),
        .outValid     (outValid),
        .fpResult     (fpResult),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns just after the accepting edge.
    task automatic start(input FpConverterCommand c, input logic [2:0] rmv, input logic [31:0] src);
        int n;
        n = 0;
        while (!inReady && n < 100) begin
            tick();
            n++;
        end
        check("start_ready", {31'd0, inReady}, 32'd1);
        command      = c;
        roundingMode = rmv;
        intSrc       = src;
        inValid      = 1'b1;
        tick();
        inValid      = 1'b0;
    endtask

    // Waits for outValid; cycle 1 is the one right after the accepting edge.
    task automatic wait_result(input string tag, input logic [31:0] exp_fp, input logic exp_nx,
                               input int exp_cyc);
        int cyc;
        cyc = 1;
        while (!outValid && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_valid"}, {31'd0, outValid}, 32'd1);
        check({tag, "_fp"}, fpResult, exp_fp);
        check({tag, "_flags"}, {27'd0, flags}, {27'd0, 4'd0, exp_nx});
        if (exp_cyc > 0) check({tag, "_lat"}, cyc, exp_cyc);
    endtask

    task automatic convert(input string tag, input FpConverterCommand c, input logic [2:0] rmv,
                           input logic [31:0] src, input logic [31:0] exp_fp, input logic exp_nx,
                           input int exp_cyc);
        start(c, rmv, src);
        wait_result(tag, exp_fp, exp_nx, exp_cyc);
        tick();
        check({tag, "_pulse"}, {31'd0, outValid}, 32'd0);
    endtask

    initial begin
        logic seen;
        logic [31:0] held;

        tick();
        tick();
        check("rst_ready", {31'd0, inReady}, 32'd0);
        check("rst_valid", {31'd0, outValid}, 32'd0);
        check("rst_fp", fpResult, 32'd0);
        check("rst_flags", {27'd0, flags}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", {31'd0, inReady}, 32'd1);

        convert("one_rne",     FpConverterCommand_S_W,  FRM_RNE, 32'h00000001, 32'h3F800000, 1'b0, 13);
        convert("m1_rne",      FpConverterCommand_S_W,  FRM_RNE, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 13);
        convert("min_sw",      FpConverterCommand_S_W,  FRM_RNE, 32'h80000000, 32'hCF000000, 1'b0, 3);
        convert("min_swu",     FpConverterCommand_S_WU, FRM_RNE, 32'h80000000, 32'h4F000000, 1'b0, 3);
        convert("max_rne",     FpConverterCommand_S_W,  FRM_RNE, 32'h7FFFFFFF, 32'h4F000000, 1'b1, 4);
        convert("max_rtz",     FpConverterCommand_S_W,  FRM_RTZ, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1, 4);
        convert("umax_rup",    FpConverterCommand_S_WU, FRM_RUP, 32'hFFFFFFFF, 32'h4F800000, 1'b1, 3);
        convert("umax_rdn",    FpConverterCommand_S_WU, FRM_RDN, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b1, 3);
        convert("tie_rne",     FpConverterCommand_S_W,  FRM_RNE, 32'h01000001, 32'h4B800000, 1'b1, 7);
        convert("tie_rmm",     FpConverterCommand_S_W,  FRM_RMM, 32'h01000001, 32'h4B800001, 1'b1, 7);
        convert("neg_rdn",     FpConverterCommand_S_W,  FRM_RDN, 32'hFEFFFFFF, 32'hCB800001, 1'b1, -1);
        convert("neg_rup",     FpConverterCommand_S_W,  FRM_RUP, 32'hFEFFFFFF, 32'hCB800000, 1'b1, -1);
        convert("m5_rne",      FpConverterCommand_S_W,  FRM_RNE, 32'hFFFFFFFB, 32'hC0A00000, 1'b0, -1);
        convert("zero_rdn",    FpConverterCommand_S_W,  FRM_RDN, 32'h00000000, 32'h00000000, 1'b0, 2);

        // Back-to-back: issue the next request in the outValid cycle.
        start(FpConverterCommand_S_W, FRM_RNE, 32'hFFFFFFFF);
        wait_result("b2b_a", 32'hBF800000, 1'b0, 13);
        check("b2b_ready", {31'd0, inReady}, 32'd1);
        start(FpConverterCommand_S_W, FRM_RNE, 32'h00000003);
        wait_result("b2b_b", 32'h40400000, 1'b0, -1);
        tick();

        // kill with inValid while idle must not accept.
        kill    = 1'b1;
        inValid = 1'b1;
        intSrc  = 32'h00000001;
        tick();
        kill    = 1'b0;
        inValid = 1'b0;
        check("kill_idle_ready", {31'd0, inReady}, 32'd1);

        // kill mid-NORM: no result, back to idle, previous result kept.
        held = fpResult;
        start(FpConverterCommand_S_W, FRM_RNE, 32'h00000001);
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_ready", {31'd0, inReady}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= outValid;
            tick();
        end
        check("kill_no_valid", {31'd0, seen}, 32'd0);
        check("kill_fp_held", fpResult, held);
        check("kill_fp_val", fpResult, 32'h40400000);

        // Async reset mid-NORM clears outputs without waiting for an edge.
        start(FpConverterCommand_S_W, FRM_RNE, 32'h00000001);
        tick();
        rst = 1'b1;
        #1;
        check("arst_ready", {31'd0, inReady}, 32'd0);
        check("arst_valid", {31'd0, outValid}, 32'd0);
        check("arst_fp", fpResult, 32'd0);
        check("arst_flags", {27'd0, flags}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("arst_idle", {31'd0, inReady}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= outValid;
            tick();
        end
        check("arst_no_valid", {31'd0, seen}, 32'd0);

        convert("post_rst", FpConverterCommand_S_WU, FRM_RNE, 32'h00000003, 32'h40400000, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
